mdu_seq_ctrl: RTL and testbench

//   Multi-cycle multiply/divide sequencer. It time-shares the RV32I ALU to execute MUL, MULHU, DIVU and REMU.

---
 rtl/mdu_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_mdu_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_seq_ctrl.sv
// Multi-cycle multiply/divide sequencer that borrows the core ALU.
// MUL/MULHU run a shift-add loop, DIVU/REMU a restoring divide; each
// iteration issues one ADD or SUB and captures the ALU Result and Carry.
// The hi/rem, lo/quo and mcand/dvs pairs share one register each because
// only one operation class is ever in flight.
//
// state  | meaning
// IDLE   | ready for a request, ALU not owned
// RUN    | iterating, ALU owned, one step per cycle for XLEN cycles
// DONE   | done pulse, result valid, returns to IDLE next cycle
module mdu_seq_ctrl #(
  parameter int         XLEN    = 32,
  parameter logic [3:0] ALU_ADD = 4'b0000,
  parameter logic [3:0] ALU_SUB = 4'b0001
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            ready,
  output logic            alu_req,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_carry,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] acc;      // hi for multiply, rem for divide
  logic [XLEN-1:0] lsr;      // lo for multiply, quo for divide
  logic [XLEN-1:0] opb;      // mcand for multiply, dvs for divide
  logic [CW-1:0]   counter;

  logic            is_div;
  logic [XLEN-1:0] rsh;
  logic            take;
  logic            last;
  logic [XLEN-1:0] nxt_acc;
  logic [XLEN-1:0] nxt_lsr;
  logic [XLEN-1:0] final_val;

  assign is_div = op_q[1];
  assign rsh    = {acc[XLEN-2:0], lsr[XLEN-1]};
  assign take   = acc[XLEN-1] | alu_carry;
  assign last   = (counter == CW'(XLEN - 1));

  // Next value of the shift/accumulate pair for the current iteration.
  always_comb begin
    nxt_acc = acc;
    nxt_lsr = lsr;
    if (is_div) begin
      nxt_acc = take ? alu_result : rsh;
      nxt_lsr = {lsr[XLEN-2:0], take};
    end else begin
      nxt_acc = {alu_carry & lsr[0], alu_result[XLEN-1:1]};
      nxt_lsr = {alu_result[0], lsr[XLEN-1:1]};
    end
  end

  // op[0] picks the upper half (MULHU/REMU) over the lower (MUL/DIVU).
  assign final_val = op_q[0] ? nxt_acc : nxt_lsr;

  // ALU drive and handshake decode from the registered state.
  always_comb begin
    ready    = (state == S_IDLE);
    alu_req  = (state == S_RUN);
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = ALU_ADD;
    if (state == S_RUN) begin
      if (is_div) begin
        alu_a    = rsh;
        alu_b    = opb;
        alu_ctrl = ALU_SUB;
      end else begin
        alu_a    = acc;
        alu_b    = lsr[0] ? opb : '0;
        alu_ctrl = ALU_ADD;
      end
    end
  end

  // Sequencer FSM with datapath registers; the final iteration writes result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      op_q    <= '0;
      acc     <= '0;
      lsr     <= '0;
      opb     <= '0;
      counter <= '0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start && !flush) begin
            op_q    <= op;
            acc     <= '0;
            lsr     <= rs1;
            opb     <= rs2;
            counter <= '0;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            acc     <= nxt_acc;
            lsr     <= nxt_lsr;
            counter <= counter + CW'(1);
            if (last) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= final_val;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq_ctrl.sv
// Bench for mdu_seq_ctrl: a simple ALU, a timeline/arithmetic reference
// model checked every cycle, and directed operations with literal results.
module tb_mdu_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        ready;
  logic        alu_req;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_carry;
  logic        done;
  logic [31:0] result;

  int n_err = 0;
  int n_checks = 0;

  mdu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .ready(ready), .alu_req(alu_req), .alu_a(alu_a),
    .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
    .alu_carry(alu_carry), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // ALU: add, or subtract as a + ~b + 1 so carry=1 means no borrow.
  logic [32:0] alu_sum;
  always_comb begin
    if (alu_ctrl == 4'b0001) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
    else                     alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  end
  assign alu_result = alu_sum[31:0];
  assign alu_carry  = alu_sum[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (o)
      2'd0:    ref_op = p[31:0];
      2'd1:    ref_op = p[63:32];
      2'd2:    ref_op = (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: ref_op = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference timeline: 0 idle, 1 busy, 2 done cycle.
  int          m_phase = 0;
  int          m_cnt = 0;
  logic [1:0]  m_op = 2'd0;
  logic [31:0] m_pending = 32'd0;
  logic [31:0] m_result = 32'd0;
  logic        m_done = 1'b0;
  bit          m_valid = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid  = 1'b1;
      m_phase  = 0;
      m_done   = 1'b0;
      m_result = 32'd0;
    end else if (m_valid) begin
      case (m_phase)
        0: begin
          if (start && !flush) begin
            m_phase   = 1;
            m_cnt     = 0;
            m_op      = op;
            m_pending = ref_op(op, rs1, rs2);
          end
        end
        1: begin
          if (flush) m_phase = 0;
          else begin
            m_cnt++;
            if (m_cnt == 32) begin
              m_phase  = 2;
              m_done   = 1'b1;
              m_result = m_pending;
            end
          end
        end
        default: begin
          m_phase = 0;
          m_done  = 1'b0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("ready", {31'd0, ready}, {31'd0, m_phase == 0});
      check("alu_req", {31'd0, alu_req}, {31'd0, m_phase == 1});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("result", result, m_result);
      if (m_phase == 1)
        check("alu_ctrl_run", {28'd0, alu_ctrl}, m_op[1] ? 32'd1 : 32'd0);
      if (m_phase == 0) begin
        check("alu_a_idle", alu_a, 32'd0);
        check("alu_b_idle", alu_b, 32'd0);
        check("alu_ctrl_idle", {28'd0, alu_ctrl}, 32'd0);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    rs1   = a;
    rs2   = b;
    tick();
    start = 1'b0;
  endtask

  // k = edges after the current one at which done was seen.
  task automatic wait_done(output int k, output int reqs, output bit got);
    k = 0;
    reqs = 0;
    got = 1'b0;
    while (!got && k < 60) begin
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        if (alu_req) reqs++;
        k++;
      end
    end
    tick();
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int k;
    int reqs;
    bit got;
    accept(o, a, b);
    wait_done(k, reqs, got);
    check({name, "_done_seen"}, {31'd0, got}, 32'd1);
    check({name, "_latency"}, k, 32'd32);
    check({name, "_alu_req_cycles"}, reqs, 32'd32);
    check(name, result, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  reqs;
    bit  got;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    op    = 2'd0;
    rs1   = 32'd0;
    rs2   = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    tick();

    check("model_pin_mulhu", ref_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("model_pin_divz", ref_op(2'd2, 32'd5, 32'd0), 32'hFFFF_FFFF);

    run_op("mul_7x6", 2'd0, 32'd7, 32'd6, 32'h0000_002A);
    run_op("mulhu_ff", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mul_ff", 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("divu_100_7", 2'd2, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", 2'd3, 32'd100, 32'd7, 32'd2);
    run_op("divu_msb_1", 2'd2, 32'h8000_0000, 32'd1, 32'h8000_0000);
    run_op("divu_ff_ff", 2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    run_op("divu_5_0", 2'd2, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_op("remu_5_0", 2'd3, 32'd5, 32'd0, 32'd5);

    // start pulsed mid-run must not disturb the running divide
    accept(2'd2, 32'd100, 32'd7);
    repeat (3) tick();
    start = 1'b1;
    op    = 2'd0;
    rs1   = 32'd5;
    rs2   = 32'd5;
    tick();
    start = 1'b0;
    wait_done(k, reqs, got);
    check("ignored_start_done_seen", {31'd0, got}, 32'd1);
    check("ignored_start_result", result, 32'd14);

    // flush at iteration 10
    accept(2'd0, 32'd11, 32'd13);
    repeat (10) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_ready", {31'd0, ready}, 32'd1);
    check("flush_done", {31'd0, done}, 32'd0);
    check("flush_result", result, 32'd14);
    tick();
    repeat (40) tick();
    check("flush_result_later", result, 32'd14);
    run_op("mul_3x3", 2'd0, 32'd3, 32'd3, 32'd9);

    // flush together with start in idle drops the request
    flush = 1'b1;
    start = 1'b1;
    op    = 2'd0;
    rs1   = 32'd2;
    rs2   = 32'd2;
    tick();
    flush = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("idle_flush_drop", {31'd0, ready}, 32'd1);
    tick();

    // reset at iteration 20
    accept(2'd2, 32'd1000, 32'd3);
    repeat (20) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_ready", {31'd0, ready}, 32'd1);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    tick();
    run_op("divu_9_2", 2'd2, 32'd9, 32'd2, 32'd4);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
